program_loader: RTL and testbench

Boot-time stage directly upstream of the CPU datapath. It receives a framed byte stream over a valid/ready handshake and assembles 16-bit words. It writes those words into the shared program RAM through its write port and verifies a trailing XOR checksum. It holds the datapath in reset (cpu_rst_n low) until the image is loaded and verified.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/program_loader_byte_to_word.sv | 56 +++++
 rtl/program_loader.sv | 139 +++++++++++++
 tb/tb_program_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the boot program loader and its byte assembler.
// Holds the loader state encoding, data widths and the default load address.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [15:0] DEF_BASE_ADDR = 16'h0000;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_LO  = 4'd1,
        S_LEN_HI  = 4'd2,
        S_DATA_LO = 4'd3,
        S_DATA_HI = 4'd4,
        S_WRITE   = 4'd5,
        S_CSUM_LO = 4'd6,
        S_CSUM_HI = 4'd7,
        S_CHECK   = 4'd8,
        S_DONE    = 4'd9,
        S_ERR     = 4'd10
    } ld_state_t;

endpackage

// File: rtl/program_loader_byte_to_word.sv
// Little-endian 2-byte assembler with a valid/ready byte handshake.
// Ports: i_clr restarts pairing, i_en grants ready, o_peek = {byte, low},
// o_word/o_valid = registered word, valid one cycle after the high byte.
module byte_to_word
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [WORD_W-1:0] o_peek,
    output logic [WORD_W-1:0] o_word,
    output logic              o_valid
);

    logic              r_phase;
    logic [BYTE_W-1:0] r_lo;
    logic [WORD_W-1:0] r_word;
    logic              r_valid;
    logic              w_xfer;

    assign o_ready = i_en;
    assign w_xfer  = i_valid & i_en;
    // Lets the owner act on a complete word in the same cycle as the high byte
    assign o_peek  = {i_byte, r_lo};
    assign o_word  = r_word;
    assign o_valid = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_lo    <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clr) begin
                r_phase <= 1'b0;
                r_lo    <= '0;
            end else if (w_xfer) begin
                if (!r_phase) begin
                    r_lo    <= i_byte;
                    r_phase <= 1'b1;
                end else begin
                    r_word  <= {i_byte, r_lo};
                    r_valid <= 1'b1;
                    r_phase <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: framed byte stream -> program RAM writes, XOR-checksum verify,
// holds the datapath in reset (cpu_rst_n low) until the image is good.
// Ports: clk/rst, start, byte_in/byte_valid/byte_ready stream,
// mem_addr/mem_data/mem_wren RAM port, cpu_rst_n, busy/done/error, words_loaded.
module program_loader
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter int                MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);

    localparam logic [31:0] MAXW = 32'(MAX_WORDS);

    ld_state_t         r_state;
    ld_state_t         w_next;
    logic [WORD_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [WORD_W-1:0] r_csum;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;

    logic              w_en;
    logic              w_xfer;
    logic              w_idle;
    logic              w_go;
    logic              w_big;
    logic              w_last;
    logic [WORD_W-1:0] w_peek;
    logic [WORD_W-1:0] w_word;
    logic              w_word_vld;

    assign w_en = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA_LO,
                                  S_DATA_HI, S_CSUM_LO, S_CSUM_HI};
    assign w_xfer = byte_valid & byte_ready;
    assign w_idle = r_state inside {S_IDLE, S_DONE, S_ERR};
    assign w_go   = start & w_idle;
    assign w_big  = {16'h0, w_peek} > MAXW;
    assign w_last = (32'(r_idx) + 32'd1) == 32'(r_len);

    byte_to_word u_b2w (
        .clk     (clk),
        .rst_n   (rst),
        .i_clr   (w_go),
        .i_en    (w_en),
        .i_byte  (byte_in),
        .i_valid (byte_valid),
        .o_ready (byte_ready),
        .o_peek  (w_peek),
        .o_word  (w_word),
        .o_valid (w_word_vld)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR:
                if (start) w_next = S_LEN_LO;
            S_LEN_LO:
                if (w_xfer) w_next = S_LEN_HI;
            S_LEN_HI:
                if (w_xfer) begin
                    if (w_big)             w_next = S_ERR;
                    else if (w_peek == '0) w_next = S_CSUM_LO;
                    else                   w_next = S_DATA_LO;
                end
            S_DATA_LO:
                if (w_xfer) w_next = S_DATA_HI;
            S_DATA_HI:
                if (w_xfer) w_next = S_WRITE;
            S_WRITE:
                w_next = w_last ? S_CSUM_LO : S_DATA_LO;
            S_CSUM_LO:
                if (w_xfer) w_next = S_CSUM_HI;
            S_CSUM_HI:
                if (w_xfer) w_next = S_CHECK;
            // received checksum word is assembled by now
            S_CHECK:
                if (w_word_vld)
                    w_next = (w_word == r_csum) ? S_DONE : S_ERR;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_csum  <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_len  <= '0;
                r_idx  <= '0;
                r_csum <= '0;
            end
            if (w_xfer && r_state == S_LEN_HI)
                r_len <= w_peek;
            // address/data staged here so they are stable through WRITE
            if (w_xfer && r_state == S_DATA_HI) begin
                r_addr <= BASE_ADDR + r_idx;
                r_data <= w_peek;
            end
            if (r_state == S_WRITE) begin
                r_csum <= r_csum ^ r_data;
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign mem_addr     = r_addr;
    assign mem_data     = r_data;
    assign mem_wren     = (r_state == S_WRITE);
    assign cpu_rst_n    = (r_state == S_DONE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign busy         = ~w_idle;
    assign words_loaded = r_idx;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, bad checksum, oversize/empty,
// back-pressure, async reset mid-load and reload behaviour.
module tb_program_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int total = 0;
    int bad = 0;
    int nwr = 0;
    int wr_rdy = 0;
    bit gap_en = 1'b0;
    logic [15:0] ram [int];

    bq_t nom = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                 8'h0F, 8'h0F, 8'hF6, 8'hB6};
    bq_t badq = '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                  8'h0F, 8'h0F, 8'hF7, 8'hB6};

    program_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wren) begin
            ram[int'(mem_addr)] = mem_data;
            nwr++;
            if (byte_ready) wr_rdy++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        if (gap_en)
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_q(input bq_t q);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic clear();
        ram.delete();
        nwr = 0;
    endtask

    task automatic chk_ram(input string tag);
        chk({tag, "_w0"}, 32'(ram[0]), 32'h1234);
        chk({tag, "_w1"}, 32'(ram[1]), 32'hABCD);
        chk({tag, "_w2"}, 32'(ram[2]), 32'h0F0F);
        chk({tag, "_nwr"}, 32'(nwr), 32'd3);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

        // nominal load
        clear();
        pulse_start();
        chk("nom_busy", 32'(busy), 32'd1);
        send_q(nom);
        wait_idle();
        chk("nom_done", 32'(done), 32'd1);
        chk("nom_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("nom_error", 32'(error), 32'd0);
        chk("nom_wl", 32'(words_loaded), 32'd3);
        chk_ram("nom");
        chk("nom_wren_off", 32'(mem_wren), 32'd0);
        chk("nom_addr_hold", 32'(mem_addr), 32'd2);
        chk("nom_data_hold", 32'(mem_data), 32'h0F0F);

        // reload from DONE, start ignored mid-load
        clear();
        pulse_start();
        chk("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("reload_wl", 32'(words_loaded), 32'd0);
        chk("reload_done", 32'(done), 32'd0);
        send_q('{8'h03, 8'h00, 8'h34, 8'h12});
        @(posedge clk); #1;
        pulse_start();
        chk("ign_busy", 32'(busy), 32'd1);
        send_q('{8'hCD, 8'hAB, 8'h0F, 8'h0F, 8'hF6, 8'hB6});
        wait_idle();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_wl", 32'(words_loaded), 32'd3);
        chk_ram("ign");

        // bad checksum
        clear();
        pulse_start();
        send_q(badq);
        wait_idle();
        chk("bad_error", 32'(error), 32'd1);
        chk("bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("bad_done", 32'(done), 32'd0);
        chk_ram("bad");

        // oversize header (N=257)
        clear();
        pulse_start();
        send_q('{8'h01, 8'h01});
        chk("big_error", 32'(error), 32'd1);
        chk("big_busy", 32'(busy), 32'd0);
        chk("big_nwr", 32'(nwr), 32'd0);

        // empty image
        pulse_start();
        send_q('{8'h00, 8'h00, 8'h00, 8'h00});
        wait_idle();
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_wl", 32'(words_loaded), 32'd0);
        chk("empty_nwr", 32'(nwr), 32'd0);

        // gated byte_valid
        clear();
        wr_rdy = 0;
        gap_en = 1'b1;
        pulse_start();
        send_q(nom);
        wait_idle();
        gap_en = 1'b0;
        chk("bp_done", 32'(done), 32'd1);
        chk_ram("bp");
        chk("bp_ready_in_write", 32'(wr_rdy), 32'd0);

        // async reset after second word written
        clear();
        pulse_start();
        send_q('{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB});
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_wren", 32'(mem_wren), 32'd0);
        chk("mid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("mid_wl", 32'(words_loaded), 32'd0);
        chk("mid_addr", 32'(mem_addr), 32'd0);
        byte_in = 8'h0F;
        byte_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_nwr", 32'(nwr), 32'd2);
        chk("mid_ready", 32'(byte_ready), 32'd0);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        clear();
        pulse_start();
        send_q(nom);
        wait_idle();
        chk("post_done", 32'(done), 32'd1);
        chk("post_wl", 32'(words_loaded), 32'd3);
        chk_ram("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
